// File: rtl/spi_slave_sync.sv
// Mode-0 SPI responder oversampled on the system clock, MSB first.
// Build option: SPI_SLAVE_MISO_HIZ_EN tri-states MISO while deselected.
module spi_slave_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SCLK,
   input  logic             SS,
   input  logic             MOSI,
   input  logic [WIDTH-1:0] data_tx,
   output logic             MISO,
   output logic [WIDTH-1:0] data_rx,
   output logic             rx_valid,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   ss_d;

   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise, sclk_fall;
   logic ss_fall, ss_rise;

   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-2:0] rx_shift;
   logic [WIDTH-1:0] rx_next;
   logic [CW-1:0]    bit_cnt;
   logic             miso_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ss_d      <= ss_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_fall   = ~ss_s & ss_d;
   assign ss_rise   = ss_s & ~ss_d;
   assign rx_next   = {rx_shift, mosi_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ss_fall) state_nxt = SHIFT;
         SHIFT:   if (ss_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_shift <= '0;
         rx_shift <= '0;
         bit_cnt  <= '0;
         miso_q   <= 1'b0;
         data_rx  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               miso_q  <= 1'b0;
               bit_cnt <= '0;
               if (ss_fall) begin
                  tx_shift <= data_tx;
                  miso_q   <= data_tx[WIDTH-1];
               end
            end
            SHIFT: begin
               // the final rise completes the word even if SS rises with it
               if (sclk_rise && bit_cnt == LAST) begin
                  data_rx  <= rx_next;
                  rx_valid <= 1'b1;
               end
               if (ss_rise) begin
                  bit_cnt <= '0;
                  miso_q  <= 1'b0;
               end else if (sclk_rise) begin
                  rx_shift <= rx_next[WIDTH-2:0];
                  if (bit_cnt == LAST) begin
                     bit_cnt  <= '0;
                     tx_shift <= data_tx;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  if (bit_cnt == '0) begin
                     miso_q <= tx_shift[WIDTH-1];
                  end else begin
                     miso_q   <= tx_shift[WIDTH-2];
                     tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SHIFT);

`ifdef SPI_SLAVE_MISO_HIZ_EN
   assign MISO = (ss_s || !rst) ? 1'bz : miso_q;
`else
   assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: mode-0 master model, SCLK = clk/8.
// Honours SPI_SLAVE_MISO_HIZ_EN for the expected idle MISO level.
module tb_spi_slave_sync;

   logic       clk;
   logic       rst;
   logic       SCLK;
   logic       SS;
   logic       MOSI;
   logic [7:0] data_tx;
   logic       MISO;
   logic [7:0] data_rx;
   logic       rx_valid;
   logic       busy;

   int n_chk;
   int n_fail;
   int rx_cnt;
   int cnt0;

   logic [7:0] got;

`ifdef SPI_SLAVE_MISO_HIZ_EN
   localparam logic IDLE_MISO = 1'bz;
`else
   localparam logic IDLE_MISO = 1'b0;
`endif

   spi_slave_sync #(
      .WIDTH      (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .SCLK    (SCLK),
      .SS      (SS),
      .MOSI    (MOSI),
      .data_tx (data_tx),
      .MISO    (MISO),
      .data_rx (data_rx),
      .rx_valid(rx_valid),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (rx_valid === 1'b1) rx_cnt++;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ss_low();
      SS = 1'b0;
      #80;
   endtask

   task automatic ss_high();
      #40;
      SS = 1'b1;
      #80;
   endtask

   task automatic word(input  logic [7:0] mo,
                       output logic [7:0] mi,
                       input  bit         chg,
                       input  logic [7:0] ntx);
      for (int i = 7; i >= 0; i--) begin
         MOSI = mo[i];
         if (chg && i == 0) data_tx = ntx;
         #40;
         mi[i] = MISO;
         SCLK = 1'b1;
         #40;
         SCLK = 1'b0;
      end
   endtask

   task automatic part(input logic [7:0] mo, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         MOSI = mo[i];
         #40;
         SCLK = 1'b1;
         #40;
         SCLK = 1'b0;
      end
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rx_cnt  = 0;
      rst     = 1'b0;
      SCLK    = 1'b0;
      SS      = 1'b1;
      MOSI    = 1'b0;
      data_tx = 8'h00;
      #20;
      check("rst_miso", 32'(MISO), 32'(IDLE_MISO));
      check("rst_data_rx", 32'(data_rx), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b1;
      #40;

      // single word
      data_tx = 8'h3C;
      cnt0 = rx_cnt;
      check("pre_ss_miso", 32'(MISO), 32'(IDLE_MISO));
      ss_low();
      check("sel_busy", 32'(busy), 32'h1);
      check("sel_miso_msb", 32'(MISO), 32'h0);
      word(8'hA5, got, 1'b0, 8'h00);
      check("w1_miso", 32'(got), 32'h3C);
      check("w1_data_rx", 32'(data_rx), 32'hA5);
      check("w1_busy_hold", 32'(busy), 32'h1);
      ss_high();
      check("w1_rx_cnt", 32'(rx_cnt - cnt0), 32'd1);
      check("w1_busy_end", 32'(busy), 32'h0);
      check("w1_miso_idle", 32'(MISO), 32'(IDLE_MISO));

      // abort after three bits
      cnt0 = rx_cnt;
      data_tx = 8'h81;
      ss_low();
      part(8'hFF, 3);
      ss_high();
      check("ab_rx_cnt", 32'(rx_cnt - cnt0), 32'd0);
      check("ab_data_rx", 32'(data_rx), 32'hA5);
      check("ab_busy", 32'(busy), 32'h0);
      data_tx = 8'h96;
      ss_low();
      check("ab2_miso_msb", 32'(MISO), 32'h1);
      word(8'h5A, got, 1'b0, 8'h00);
      ss_high();
      check("ab2_miso", 32'(got), 32'h96);
      check("ab2_data_rx", 32'(data_rx), 32'h5A);
      check("ab2_rx_cnt", 32'(rx_cnt - cnt0), 32'd1);

      // back-to-back words in one selection
      cnt0 = rx_cnt;
      data_tx = 8'hF0;
      ss_low();
      word(8'h12, got, 1'b1, 8'h0F);
      check("b2b1_miso", 32'(got), 32'hF0);
      check("b2b1_data_rx", 32'(data_rx), 32'h12);
      check("b2b1_rx_cnt", 32'(rx_cnt - cnt0), 32'd1);
      word(8'h34, got, 1'b0, 8'h00);
      check("b2b2_miso", 32'(got), 32'h0F);
      check("b2b2_data_rx", 32'(data_rx), 32'h34);
      ss_high();
      check("b2b_rx_cnt", 32'(rx_cnt - cnt0), 32'd2);

      // SCLK noise while deselected
      cnt0 = rx_cnt;
      for (int i = 0; i < 20; i++) begin
         SCLK = ~SCLK;
         MOSI = 1'($urandom);
         #40;
         if (i == 9) check("nz_busy_mid", 32'(busy), 32'h0);
      end
      #40;
      check("nz_rx_cnt", 32'(rx_cnt - cnt0), 32'd0);
      check("nz_busy", 32'(busy), 32'h0);
      check("nz_miso", 32'(MISO), 32'(IDLE_MISO));
      check("nz_data_rx", 32'(data_rx), 32'h34);

      // reset in the middle of a word
      data_tx = 8'hAA;
      ss_low();
      part(8'hC3, 4);
      rst = 1'b0;
      #1;
      check("mr_miso", 32'(MISO), 32'(IDLE_MISO));
      check("mr_busy", 32'(busy), 32'h0);
      check("mr_rx_valid", 32'(rx_valid), 32'h0);
      check("mr_data_rx", 32'(data_rx), 32'h00);
      #19;
      SS = 1'b1;
      rst = 1'b1;
      #40;
      cnt0 = rx_cnt;
      data_tx = 8'h81;
      ss_low();
      word(8'hC3, got, 1'b0, 8'h00);
      ss_high();
      check("mr2_miso", 32'(got), 32'h81);
      check("mr2_data_rx", 32'(data_rx), 32'hC3);
      check("mr2_rx_cnt", 32'(rx_cnt - cnt0), 32'd1);
      check("mr2_busy", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
